// File: rtl/riscv_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_pipeline_ctrl
//
// Pipeline control for a simple in-order RISC-V core (IF / ID / EX). Each cycle
// this block picks one action, in this priority order:
//   1. redirect  - EX resolved a mispredict, so the younger stages are squashed
//   2. busy      - a multicycle EX op holds the whole front end
//   3. load-use  - IF and ID hold, and a bubble goes into EX
//   4. advance   - every stage moves forward
// It also keeps the ID/EX valid bits and two saturating event counters.
//
// Ports
//   clk           in   1            rising-edge clock
//   rst_n         in   1            asynchronous active-low reset
//   fetch_valid   in   1            IF holds a valid fetched instruction
//   hz_stall      in   1            load-use stall request (combinational)
//   ex_busy       in   1            multicycle EX operation still running
//   ex_redirect   in   1            EX branch/jump mispredict, target valid
//   pc_en         out  1            PC load enable (sequential or redirect)
//   ifid_en       out  1            IF/ID register write enable
//   idex_en       out  1            ID/EX register write enable
//   id_valid      out  1            registered ID-stage valid
//   ex_valid      out  1            registered EX-stage valid
//   ctrl_state    out  2            FSM state: RUN=0, BUSY=1, FLUSH=2
//   stall_cycles  out  STALL_CNT_W  saturating count of cycles with ifid_en=0
//   flush_count   out  FLUSH_CNT_W  saturating count of accepted redirects
// -----------------------------------------------------------------------------
module riscv_pipeline_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int FLUSH_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_valid,
    input  logic                   hz_stall,
    input  logic                   ex_busy,
    input  logic                   ex_redirect,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   id_valid,
    output logic                   ex_valid,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   id_valid_q, id_valid_d;
    logic                   ex_valid_q, ex_valid_d;
    logic                   pc_en_c, ifid_en_c, idex_en_c;
    logic                   redirect_acc;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [FLUSH_CNT_W-1:0] flush_q;

    // Next-state and enable decode. BUSY evaluates exactly like RUN: once
    // ex_busy drops, that same cycle may already take a redirect or a stall.
    // Only FLUSH changes the decision, because the squashed EX slot must not
    // act on a redirect or a stall.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d      = ST_RUN;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        id_valid_d   = fetch_valid;
        ex_valid_d   = id_valid_q;
        redirect_acc = 1'b0;

        if (state_q == ST_FLUSH) begin
            // One refill cycle: fetch at the redirect target, EX stays empty.
            ex_valid_d = 1'b0;
        end else if (ex_redirect && ex_valid_q && !ex_busy) begin
            redirect_acc = 1'b1;
            ifid_en_c    = 1'b0;
            idex_en_c    = 1'b0;
            id_valid_d   = 1'b0;
            ex_valid_d   = 1'b0;
            state_d      = ST_FLUSH;
        end else if (ex_busy && ex_valid_q) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            id_valid_d = id_valid_q;
            ex_valid_d = ex_valid_q;
            state_d    = ST_BUSY;
        end else if (hz_stall && id_valid_q) begin
            // Load-use: hold IF/ID, let ID/EX load a bubble.
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            id_valid_d = id_valid_q;
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            id_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            // NOTE: all state updates use non-blocking assignments, so every
            // register here samples the pre-edge values of the others.
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            ex_valid_q <= ex_valid_d;
            if (!ifid_en_c && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
            if (redirect_acc && (flush_q != '1)) begin
                flush_q <= flush_q + FLUSH_CNT_W'(1);
            end
        end
    end

    // The enables are gated by rst_n directly, so they drop together with
    // the registered state the moment reset asserts, without waiting for clk.
    assign pc_en        = rst_n & pc_en_c;
    assign ifid_en      = rst_n & ifid_en_c;
    assign idex_en      = rst_n & idex_en_c;
    assign id_valid     = id_valid_q;
    assign ex_valid     = ex_valid_q;
    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_pipeline_ctrl
//
// Scoreboard bench. The stimulus process drives inputs 1 ns after each rising
// edge, asks the reference model what every output should show during that
// cycle, and queues the result. The monitor samples the DUT on each falling
// edge and compares it with the oldest queued entry. Small counter widths are
// used so that saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_riscv_pipeline_ctrl;

    localparam int SW        = 4;
    localparam int FW        = 2;
    localparam int STALL_MAX = (1 << SW) - 1;
    localparam int FLUSH_MAX = (1 << FW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_valid = 1'b0;
    logic          hz_stall = 1'b0;
    logic          ex_busy = 1'b0;
    logic          ex_redirect = 1'b0;
    logic          pc_en, ifid_en, idex_en, id_valid, ex_valid;
    logic [1:0]    ctrl_state;
    logic [SW-1:0] stall_cycles;
    logic [FW-1:0] flush_count;

    riscv_pipeline_ctrl #(.STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .hz_stall     (hz_stall),
        .ex_busy      (ex_busy),
        .ex_redirect  (ex_redirect),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .id_valid     (id_valid),
        .ex_valid     (ex_valid),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc, ifid, idex, idv, exv, st, stall, flush;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: valid bits, a FLUSH/BUSY/RUN code, event counts.
    int m_id = 0, m_ex = 0, m_state = 0, m_stall = 0, m_flush = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock cycle of stimulus. rst=0 asserts reset for this cycle; it is
    // applied 1 ns after the edge, i.e. asynchronously to the clock.
    task automatic drive(input bit rst, input bit fv, input bit hz,
                         input bit bz, input bit rd);
        exp_t e;
        int   kind;   // 0 advance, 1 redirect, 2 busy, 3 load-use, 4 flush refill
        @(posedge clk);
        #1;
        rst_n       = rst;
        fetch_valid = fv;
        hz_stall    = hz;
        ex_busy     = bz;
        ex_redirect = rd;
        if (!rst) begin
            e = '{0, 0, 0, 0, 0, 0, 0, 0};
            m_id = 0; m_ex = 0; m_state = 0; m_stall = 0; m_flush = 0;
            q.push_back(e);
            return;
        end
        if (m_state == 2)                   kind = 4;
        else if (rd && m_ex == 1 && !bz)    kind = 1;
        else if (bz && m_ex == 1)           kind = 2;
        else if (hz && m_id == 1)           kind = 3;
        else                                kind = 0;

        e.idv   = m_id;
        e.exv   = m_ex;
        e.st    = m_state;
        e.stall = m_stall;
        e.flush = m_flush;
        e.pc    = (kind == 2 || kind == 3) ? 0 : 1;
        e.ifid  = (kind == 1 || kind == 2 || kind == 3) ? 0 : 1;
        e.idex  = (kind == 1 || kind == 2) ? 0 : 1;
        q.push_back(e);

        if (e.ifid == 0 && m_stall < STALL_MAX) m_stall++;
        case (kind)
            1: begin
                m_id = 0; m_ex = 0; m_state = 2;
                if (m_flush < FLUSH_MAX) m_flush++;
            end
            2: m_state = 1;
            3: begin m_ex = 0; m_state = 0; end
            4: begin m_id = fv; m_ex = 0; m_state = 0; end
            default: begin m_ex = m_id; m_id = fv; m_state = 0; end
        endcase
    endtask

    // Monitor: every falling edge, compare the DUT with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc_en",        int'(pc_en),        e.pc);
                check("ifid_en",      int'(ifid_en),      e.ifid);
                check("idex_en",      int'(idex_en),      e.idex);
                check("id_valid",     int'(id_valid),     e.idv);
                check("ex_valid",     int'(ex_valid),     e.exv);
                check("ctrl_state",   int'(ctrl_state),   e.st);
                check("stall_cycles", int'(stall_cycles), e.stall);
                check("flush_count",  int'(flush_count),  e.flush);
            end
        end
    end

    initial begin
        bit bz_prev;
        bit bz, rd, hz, fv;
        int waited;

        // Reset, then fill the pipe with three valid fetches.
        repeat (2) drive(0, 0, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 0);
        // Single load-use stall with ID valid.
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        // Four busy cycles with a concurrent stall request, then release.
        repeat (4) drive(1, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0);
        // Redirect competing with a load-use stall, then FLUSH and refill.
        drive(1, 1, 1, 0, 1);
        repeat (3) drive(1, 1, 0, 0, 0);
        // Five redirects to saturate flush_count.
        repeat (5) begin
            drive(1, 1, 0, 0, 1);
            repeat (2) drive(1, 1, 0, 0, 0);
        end
        // Twenty consecutive load-use stalls to saturate stall_cycles.
        repeat (20) drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        // Reset asserted in the middle of a busy period, between clock edges.
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(0, 1, 1, 1, 1);
        drive(1, 1, 1, 1, 1);

        // Randomized episodes, with occasional asynchronous resets.
        bz_prev = 0;
        for (int ep = 0; ep < 8; ep++) begin
            drive(0, 0, 0, 0, 0);
            for (int c = 0; c < 150; c++) begin
                bz = bz_prev ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                rd = ($urandom_range(0, 99) < 15);
                hz = ($urandom_range(0, 99) < 30);
                fv = ($urandom_range(0, 99) < 80);
                if ($urandom_range(0, 99) < 2) begin
                    drive(0, fv, hz, bz, rd);
                    bz_prev = 0;
                end else begin
                    drive(1, fv, hz, bz, rd);
                    bz_prev = bz;
                end
            end
        end

        // Let the monitor drain the queue, within a bounded wait.
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_pipeline_ctrl.md
RISCV_PIPELINE_CTRL -- requirements
Module: riscv_pipeline_ctrl

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 SHALL have parameter FLUSH_CNT_W, default 8, width of the saturating redirect counter.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 SHALL provide rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide fetch_valid  input  1  IF holds a valid fetched instruction this cycle.
REQ-006 SHALL provide hz_stall  input  1  load-use stall request from hazard detection, same-cycle combinational.
REQ-007 SHALL provide ex_busy  input  1  multicycle EX operation not yet complete.
REQ-008 SHALL provide ex_redirect  input  1  EX-resolved branch/jump mispredict, PC target valid this cycle.
REQ-009 SHALL provide pc_en  output  1  PC register load enable (sequential or redirect target).
REQ-010 SHALL provide ifid_en  output  1  IF/ID pipeline register write enable.
REQ-011 SHALL provide idex_en  output  1  ID/EX pipeline register write enable.
REQ-012 SHALL provide id_valid  output  1  registered valid bit of the ID stage.
REQ-013 SHALL provide ex_valid  output  1  registered valid bit of the EX stage.
REQ-014 SHALL provide ctrl_state  output  2  current FSM state (RUN=0, BUSY=1, FLUSH=2).
REQ-015 SHALL provide stall_cycles  output  STALL_CNT_W  saturating count of cycles with ifid_en=0.
REQ-016 SHALL provide flush_count  output  FLUSH_CNT_W  saturating count of accepted redirects.

Function
REQ-017 SHALL evaluate per cycle with priority: redirect > busy > load-use stall > advance.
REQ-018 SHALL accept a redirect only when ex_redirect=1, ex_valid=1, ex_busy=0, state!=FLUSH.
REQ-019 On accepted redirect: pc_en=1, ifid_en=0, idex_en=0; next id_valid=0, ex_valid=0; next state FLUSH; flush_count+1.
REQ-020 Busy (ex_busy=1 and ex_valid=1): pc_en=0, ifid_en=0, idex_en=0; id_valid/ex_valid held; state BUSY, ex_redirect ignored.
REQ-021 BUSY SHALL return to RUN in the cycle after ex_busy deasserts; that cycle SHALL evaluate as RUN (redirect or stall may apply).
REQ-022 Load-use (hz_stall=1 and id_valid=1, no higher case): pc_en=0, ifid_en=0, idex_en=1; next ex_valid=0 (bubble); id_valid held.
REQ-023 hz_stall SHALL be ignored when id_valid=0 or state=FLUSH.
REQ-024 Advance (no other case): pc_en=1, ifid_en=1, idex_en=1; next id_valid=fetch_valid; next ex_valid=id_valid.
REQ-025 FLUSH SHALL last exactly one cycle: pc_en=1, ifid_en=1, idex_en=1, next id_valid=fetch_valid, next ex_valid=0, next state RUN.
REQ-026 ex_busy with ex_valid=0 SHALL be ignored.
REQ-027 stall_cycles SHALL increment in every post-reset cycle with ifid_en=0, saturating at all-ones, never wrapping.
REQ-028 flush_count SHALL saturate at all-ones, never wrapping.
REQ-029 Back-to-back load-use stalls SHALL be honored each cycle hz_stall remains asserted.

Reset
REQ-030 While rst_n=0: id_valid=0, ex_valid=0, ctrl_state=RUN, stall_cycles=0, flush_count=0, pc_en=0, ifid_en=0, idex_en=0, independent of clk.
REQ-031 Reset asserted mid-BUSY or mid-FLUSH SHALL abort immediately; first cycle after release SHALL evaluate as RUN with empty ID/EX.

Verification
REQ-032 Reset release, fetch_valid=1 for 3 cycles -> id_valid=1 after cycle 1, ex_valid=1 after cycle 2, stall_cycles=0.
REQ-033 id_valid=1, hz_stall=1 one cycle -> pc_en=0, ifid_en=0, idex_en=1; next ex_valid=0, id_valid=1; stall_cycles=1.
REQ-034 ex_valid=1, ex_busy=1 for 4 cycles, then hz_stall=1 concurrently -> BUSY 4 cycles, hz_stall ignored, stall_cycles=4, valids held.
REQ-035 ex_valid=1, ex_redirect=1 with hz_stall=1 -> pc_en=1, both valids cleared, state FLUSH one cycle then RUN, flush_count=1.
REQ-036 FLUSH_CNT_W=2, 5 accepted redirects -> flush_count=3; STALL_CNT_W=4, 20 stall cycles -> stall_cycles=15.
REQ-037 rst_n asserted during BUSY without clk edge -> all outputs at REQ-030 values immediately.
